// File: rtl/mac_pkg.sv
// Shared types and width helpers for the mac_array_ctrl engine.
// Build option: MAC_SIGNED_EN selects two's-complement operands (see dot_pipe).
package mac_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    FULL  = 2'd2,
    READ  = 2'd3
  } state_t;

  // Pipeline depth: one product register plus one register per adder-tree level.
  function automatic int calc_lat(input int lanes);
    return 1 + $clog2(lanes);
  endfunction

  // Result width: full product width plus one carry bit per tree level.
  function automatic int calc_rw(input int opw, input int lanes);
    return 2 * opw + $clog2(lanes);
  endfunction

endpackage

// File: rtl/mac_array_ctrl_dot_pipe.sv
// dot_pipe: registered lane products feeding a registered binary adder tree,
// with a valid bit shifted alongside. No stall, no bubble compression.
// Build option: MAC_SIGNED_EN -> operands/products/sums are two's-complement.
module dot_pipe
  import mac_pkg::*;
#(
  parameter  int LANES = 4,
  parameter  int OPW   = 16,
  parameter  int LAT   = calc_lat(LANES),
  localparam int RW    = calc_rw(OPW, LANES)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 i_vld,
  input  logic [LANES*OPW-1:0] i_a,
  input  logic [LANES*OPW-1:0] i_b,
  output logic                 o_vld,
  output logic [RW-1:0]        o_sum
);

  // Tree kept as a heap: node n sums children 2n+1 and 2n+2, leaves sit at
  // LANES-1 .. 2*LANES-2 and hold the products, node 0 is the final sum.
  // Every node is carried at RW bits; the extension to RW is done once at
  // the product, which gives the same value as widening by one bit per level.
  logic [RW-1:0]  w_prod [LANES];
  logic [RW-1:0]  r_node [2*LANES-1];
  logic [LAT-1:0] r_vld;

  // Per-lane product, extended to the result width.
  always_comb begin
    w_prod = '{default: '0};
    for (int unsigned i = 0; i < LANES; i++) begin
`ifdef MAC_SIGNED_EN
      w_prod[i] = RW'($signed(i_a[i*OPW +: OPW])) * RW'($signed(i_b[i*OPW +: OPW]));
`else
      w_prod[i] = RW'(i_a[i*OPW +: OPW]) * RW'(i_b[i*OPW +: OPW]);
`endif
    end
  end

  // Product registers and adder-tree registers; data needs no reset.
  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < LANES - 1; i++) begin
      r_node[i] <= r_node[2*i+1] + r_node[2*i+2];
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      r_node[LANES-1+i] <= w_prod[i];
    end
  end

  // Valid bit travelling with each operation.
  always_ff @(posedge CLK) begin
    if (!RST_N) r_vld <= '0;
    else        r_vld <= {r_vld[LAT-2:0], i_vld};
  end

  assign o_vld = r_vld[LAT-1];
  assign o_sum = r_node[0];

endmodule

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: dot-product MAC engine. Accepted operations go through
// dot_pipe, results are written to consecutive result-memory addresses; a
// closed block (full or flushed) is streamed back via the block-read handshake.
// Build option: MAC_SIGNED_EN (signed arithmetic, handled inside dot_pipe).
module mac_array_ctrl
  import mac_pkg::*;
#(
  parameter  int LANES = 4,
  parameter  int OPW   = 16,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int RW    = calc_rw(OPW, LANES),
  localparam int LAT   = calc_lat(LANES)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 EN_mac,
  output logic                 RDY_mac,
  input  logic [LANES*OPW-1:0] vectA,
  input  logic [LANES*OPW-1:0] vectB,
  input  logic                 EN_flush,
  input  logic                 EN_blockRead,
  output logic                 RDY_blockRead,
  output logic                 EN_writeMem,
  output logic [AW-1:0]        writeMem_addr,
  output logic [RW-1:0]        writeMem_val,
  output logic                 EN_readMem,
  output logic [AW-1:0]        readMem_addr,
  input  logic [RW-1:0]        readMem_val,
  output logic                 VALID_memVal,
  output logic [RW-1:0]        memVal_data,
  output logic [AW:0]          blk_count
);

  localparam logic [AW:0] BLK_MAX = (AW+1)'(DEPTH);

  state_t      r_state, w_state_nxt;
  logic [AW:0] r_issued, r_wr_cnt, r_rd_addr;
  logic [AW:0] w_wr_cnt_nxt;
  logic        r_mv;
  logic        w_accept, w_clear;
  logic        w_pipe_vld;
  logic [RW-1:0] w_pipe_sum;

  dot_pipe #(
    .LANES (LANES),
    .OPW   (OPW),
    .LAT   (LAT)
  ) u_dot_pipe (
    .CLK   (CLK),
    .RST_N (RST_N),
    .i_vld (w_accept),
    .i_a   (vectA),
    .i_b   (vectB),
    .o_vld (w_pipe_vld),
    .o_sum (w_pipe_sum)
  );

  // Next-state decode and handshake outputs.
  always_comb begin
    w_state_nxt   = r_state;
    RDY_mac       = 1'b0;
    RDY_blockRead = 1'b0;
    EN_readMem    = 1'b0;
    w_accept      = 1'b0;
    w_clear       = 1'b0;
    w_wr_cnt_nxt  = r_wr_cnt + (AW+1)'(w_pipe_vld);
    unique case (r_state)
      FILL: begin
        // Held low while reset is asserted so every output reads 0 then.
        RDY_mac  = RST_N && (r_issued < BLK_MAX);
        w_accept = EN_mac && RDY_mac;
        if (w_accept && (r_issued == BLK_MAX - 1'b1)) w_state_nxt = DRAIN;
        else if (EN_flush && (r_issued != '0))        w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_wr_cnt_nxt == r_issued) w_state_nxt = FULL;
      end
      FULL: begin
        RDY_blockRead = 1'b1;
        if (EN_blockRead) w_state_nxt = READ;
      end
      READ: begin
        EN_readMem = 1'b1;
        if (r_rd_addr == r_wr_cnt - 1'b1) begin
          w_state_nxt = FILL;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  // Issue, write and read counters; cleared after the last readout.
  always_ff @(posedge CLK) begin
    if (!RST_N || w_clear) begin
      r_issued  <= '0;
      r_wr_cnt  <= '0;
      r_rd_addr <= '0;
    end else begin
      if (w_accept)   r_issued <= r_issued + 1'b1;
      if (w_pipe_vld) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (r_state == FULL && EN_blockRead) r_rd_addr <= '0;
      else if (EN_readMem)                 r_rd_addr <= r_rd_addr + 1'b1;
    end
  end

  // Read data is valid one cycle after each read strobe.
  always_ff @(posedge CLK) begin
    if (!RST_N) r_mv <= 1'b0;
    else        r_mv <= EN_readMem;
  end

  assign EN_writeMem   = w_pipe_vld;
  assign writeMem_addr = r_wr_cnt[AW-1:0];
  // Tree registers are not reset, so the data is gated to read 0 when idle.
  assign writeMem_val  = w_pipe_vld ? w_pipe_sum : '0;
  assign readMem_addr  = r_rd_addr[AW-1:0];
  assign VALID_memVal  = r_mv;
  assign memVal_data   = readMem_val;
  assign blk_count     = r_wr_cnt;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl with a write scoreboard and a result-memory
// model. Honours MAC_SIGNED_EN the same way the design does.
module tb_mac_array_ctrl;
  import mac_pkg::*;

  localparam int LANES = 4;
  localparam int OPW   = 16;
  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);
  localparam int RW    = calc_rw(OPW, LANES);

  logic                 CLK = 1'b0;
  logic                 RST_N;
  logic                 EN_mac, RDY_mac, EN_flush, EN_blockRead, RDY_blockRead;
  logic [LANES*OPW-1:0] vectA, vectB;
  logic                 EN_writeMem, EN_readMem, VALID_memVal;
  logic [AW-1:0]        writeMem_addr, readMem_addr;
  logic [RW-1:0]        writeMem_val, memVal_data;
  logic [RW-1:0]        readMem_val = '0;
  logic [AW:0]          blk_count;

  mac_array_ctrl #(.LANES(LANES), .OPW(OPW), .DEPTH(DEPTH)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .EN_mac        (EN_mac),
    .RDY_mac       (RDY_mac),
    .vectA         (vectA),
    .vectB         (vectB),
    .EN_flush      (EN_flush),
    .EN_blockRead  (EN_blockRead),
    .RDY_blockRead (RDY_blockRead),
    .EN_writeMem   (EN_writeMem),
    .writeMem_addr (writeMem_addr),
    .writeMem_val  (writeMem_val),
    .EN_readMem    (EN_readMem),
    .readMem_addr  (readMem_addr),
    .readMem_val   (readMem_val),
    .VALID_memVal  (VALID_memVal),
    .memVal_data   (memVal_data),
    .blk_count     (blk_count)
  );

  always #5 CLK = ~CLK;

  // Result memory with one-cycle read latency.
  logic [RW-1:0] mem [DEPTH];
  always @(posedge CLK) begin
    if (EN_writeMem) mem[writeMem_addr] <= writeMem_val;
    if (EN_readMem)  readMem_val <= mem[readMem_addr];
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [RW-1:0] val;
    int            due;
  } exp_t;

  exp_t          sb[$];
  logic [RW-1:0] blk_vals [DEPTH];
  int            acc_cnt  = 0;
  int            cyc_no   = 0;
  int            checks   = 0;
  int            failures = 0;

  function automatic logic [RW-1:0] dot_ref(input logic [LANES*OPW-1:0] a, input logic [LANES*OPW-1:0] b);
    longint s = 0;
    for (int i = 0; i < LANES; i++) begin
`ifdef MAC_SIGNED_EN
      s += longint'($signed(a[i*OPW +: OPW])) * longint'($signed(b[i*OPW +: OPW]));
`else
      s += longint'(a[i*OPW +: OPW]) * longint'(b[i*OPW +: OPW]);
`endif
    end
    return RW'(s);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Records accepts into the scoreboard and checks every write against it.
  task automatic mon();
    exp_t e;
    if (EN_mac === 1'b1 && RDY_mac === 1'b1) begin
      e.addr = acc_cnt[AW-1:0];
      e.val  = dot_ref(vectA, vectB);
      e.due  = cyc_no + 3;
      sb.push_back(e);
      blk_vals[acc_cnt % DEPTH] = e.val;
      acc_cnt++;
    end
    if (EN_writeMem === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 64'(EN_writeMem), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 64'(writeMem_addr), 64'(e.addr));
        chk("wr_val", 64'(writeMem_val), 64'(e.val));
        chk("wr_cycle", 64'(cyc_no), 64'(e.due));
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc_no) begin
      chk("missing_write", 64'(EN_writeMem), 64'd1);
      void'(sb.pop_front());
    end
  endtask

  task automatic settle();
    @(negedge CLK);
    mon();
  endtask

  task automatic clk();
    @(posedge CLK);
    #1;
    cyc_no++;
  endtask

  task automatic run(input int n);
    repeat (n) begin settle(); clk(); end
  endtask

  // Returns at the negedge of the first FULL cycle, or after the budget expires.
  task automatic wait_full(input string tag, input int budget);
    int k = 0;
    settle();
    while (RDY_blockRead !== 1'b1 && k < budget) begin
      clk(); settle(); k++;
    end
    chk(tag, 64'(RDY_blockRead), 64'd1);
  endtask

  // Called from FULL (just after a posedge); streams n results back.
  task automatic readout(input int n);
    EN_blockRead = 1'b1;
    settle();
    chk("full_rdy_mac", 64'(RDY_mac), 64'd0);
    clk();
    EN_blockRead = 1'b0;
    for (int i = 0; i < n; i++) begin
      settle();
      chk("rd_en", 64'(EN_readMem), 64'd1);
      chk("rd_addr", 64'(readMem_addr), 64'(i));
      chk("rd_valid", 64'(VALID_memVal), 64'(i > 0));
      if (i > 0) chk("rd_data", 64'(memVal_data), 64'(blk_vals[i-1]));
      clk();
    end
    settle();
    chk("rd_valid_last", 64'(VALID_memVal), 64'd1);
    chk("rd_data_last", 64'(memVal_data), 64'(blk_vals[n-1]));
    chk("rd_en_done", 64'(EN_readMem), 64'd0);
    chk("rdy_mac_after_read", 64'(RDY_mac), 64'd1);
    chk("blk_count_cleared", 64'(blk_count), 64'd0);
    clk();
    settle();
    chk("rd_valid_off", 64'(VALID_memVal), 64'd0);
    clk();
    acc_cnt = 0;
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_wr"}, 64'(EN_writeMem), 64'd0);
    chk({tag, "_wr_val"}, 64'(writeMem_val), 64'd0);
    chk({tag, "_wr_addr"}, 64'(writeMem_addr), 64'd0);
    chk({tag, "_rd"}, 64'(EN_readMem), 64'd0);
    chk({tag, "_rd_addr"}, 64'(readMem_addr), 64'd0);
    chk({tag, "_valid"}, 64'(VALID_memVal), 64'd0);
    chk({tag, "_rdy_mac"}, 64'(RDY_mac), 64'd0);
    chk({tag, "_rdy_blk"}, 64'(RDY_blockRead), 64'd0);
    chk({tag, "_blk_count"}, 64'(blk_count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    RST_N = 1'b0; EN_mac = 1'b0; EN_flush = 1'b0; EN_blockRead = 1'b0;
    vectA = '0; vectB = '0;
    clk(); clk();
    settle(); chk_idle_reset("reset"); clk();
    RST_N = 1'b1;
    settle(); chk("rdy_after_reset", 64'(RDY_mac), 64'd1); clk();

    // Flush and block-read with nothing issued are ignored.
    EN_flush = 1'b1; EN_blockRead = 1'b1;
    settle(); clk();
    EN_flush = 1'b0; EN_blockRead = 1'b0;
    settle();
    chk("empty_flush_rdy_mac", 64'(RDY_mac), 64'd1);
    chk("empty_flush_rdy_blk", 64'(RDY_blockRead), 64'd0);
    chk("blockread_ignored", 64'(EN_readMem), 64'd0);
    clk();

    // Basic dot product: latency 3, address 0, value 70.
    vectA = {16'd4, 16'd3, 16'd2, 16'd1};
    vectB = {16'd8, 16'd7, 16'd6, 16'd5};
    EN_mac = 1'b1;
    settle(); chk("dot_rdy_mac", 64'(RDY_mac), 64'd1); clk();
    EN_mac = 1'b0;
    run(2);
    settle();
    chk("dot_wr_en", 64'(EN_writeMem), 64'd1);
    chk("dot_val", 64'(writeMem_val), 64'd70);
    chk("dot_addr", 64'(writeMem_addr), 64'd0);
    clk();
    settle(); chk("dot_blk_count", 64'(blk_count), 64'd1); clk();

    // Full-scale operands: no truncation of the 34-bit sum.
    vectA = '1; vectB = '1; EN_mac = 1'b1;
    settle(); clk();
    EN_mac = 1'b0;
    run(2);
    settle();
`ifdef MAC_SIGNED_EN
    chk("ovf_val", 64'(writeMem_val), 64'd4);
`else
    chk("ovf_val", 64'(writeMem_val), 64'h3_FFF8_0004);
`endif
    clk();

    // Lane 0 only: -1 * 2 in the signed build.
    vectA = 64'h0000_0000_0000_FFFF; vectB = 64'h0000_0000_0000_0002; EN_mac = 1'b1;
    settle(); clk();
    EN_mac = 1'b0;
    run(2);
    settle();
`ifdef MAC_SIGNED_EN
    chk("neg_val", 64'(writeMem_val), 64'h3_FFFF_FFFE);
`else
    chk("neg_val", 64'(writeMem_val), 64'h1_FFFE);
`endif
    clk();

    // Two more accepts, then a sixth accept together with the flush.
    for (int i = 0; i < 2; i++) begin
      vectA = {$urandom, $urandom}; vectB = {$urandom, $urandom}; EN_mac = 1'b1;
      settle(); clk();
    end
    vectA = {$urandom, $urandom}; vectB = {$urandom, $urandom}; EN_flush = 1'b1;
    settle(); clk();
    EN_flush = 1'b0;
    settle(); chk("drain_rdy_mac", 64'(RDY_mac), 64'd0); clk();
    EN_mac = 1'b0;
    wait_full("flush_full", 20);
    chk("flush_blk_count", 64'(blk_count), 64'd6);
    chk("flush_full_rdy_mac", 64'(RDY_mac), 64'd0);
    clk();
    readout(6);

    // Full block of back-to-back accepts.
    for (int i = 0; i < DEPTH; i++) begin
      vectA = {$urandom, $urandom}; vectB = {$urandom, $urandom}; EN_mac = 1'b1;
      settle(); chk("blk_rdy_mac", 64'(RDY_mac), 64'd1); clk();
    end
    settle(); chk("blk_rdy_mac_low", 64'(RDY_mac), 64'd0); clk();
    EN_mac = 1'b0;
    wait_full("blk_full", 20);
    chk("blk_full_count", 64'(blk_count), 64'd64);
    clk();
    readout(DEPTH);

    // Reset while two results are still in the pipeline.
    vectA = {$urandom, $urandom}; vectB = {$urandom, $urandom}; EN_mac = 1'b1;
    settle(); clk();
    vectA = {$urandom, $urandom}; EN_flush = 1'b1;
    settle(); clk();
    EN_mac = 1'b0; EN_flush = 1'b0; RST_N = 1'b0;
    sb.delete(); acc_cnt = 0;
    settle(); clk();
    settle(); chk_idle_reset("drain_reset"); clk();
    RST_N = 1'b1;
    settle();
    chk("drain_rst_rdy_mac", 64'(RDY_mac), 64'd1);
    chk("drain_rst_no_wr", 64'(EN_writeMem), 64'd0);
    clk();
    run(4);

    // Reset in the middle of a readout.
    for (int i = 0; i < 3; i++) begin
      vectA = {$urandom, $urandom}; vectB = {$urandom, $urandom}; EN_mac = 1'b1;
      EN_flush = (i == 2);
      settle(); clk();
    end
    EN_mac = 1'b0; EN_flush = 1'b0;
    wait_full("read_reset_full", 20);
    clk();
    EN_blockRead = 1'b1;
    settle(); clk();
    EN_blockRead = 1'b0;
    settle(); chk("read_reset_rd_en", 64'(EN_readMem), 64'd1); clk();
    RST_N = 1'b0;
    settle(); clk();
    settle(); chk_idle_reset("read_reset"); clk();
    RST_N = 1'b1;
    sb.delete(); acc_cnt = 0;
    settle();
    chk("read_rst_rdy_mac", 64'(RDY_mac), 64'd1);
    chk("read_rst_valid", 64'(VALID_memVal), 64'd0);
    clk();

    // Fresh operation after reset lands at address 0.
    vectA = {$urandom, $urandom}; vectB = {$urandom, $urandom}; EN_mac = 1'b1;
    settle(); clk();
    EN_mac = 1'b0;
    run(4);
    settle(); chk("post_reset_blk_count", 64'(blk_count), 64'd1); clk();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
